// File: rtl/frame_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : frame_sync_param
// Purpose  : Serial frame synchroniser. Hunts for a sync word, verifies it over
//            several frames, flywheels through bad sync words, and forwards only
//            payload bits with a valid strobe and frame-start marker.
// Revision : 1.0
// ============================================================================
module frame_sync_param #(
    parameter int                  SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 8'hE2,
    parameter int                  FRAME_LEN    = 40,
    parameter int                  MAX_MISMATCH = 1,
    parameter int                  VERIFY_CNT   = 2,
    parameter int                  LOSS_CNT     = 3
) (
    input  logic        clk_out,
    input  logic        rst_n,
    input  logic        data_in,
    input  logic        data_in_valid,
    output logic        is_frame_sychronized,
    output logic [2:0]  synchronizer_state,
    output logic        data_sync_out,
    output logic        data_sync_valid,
    output logic        frame_start,
    output logic        lock_loss,
    output logic [15:0] sync_bit_errors
);

    localparam int c_pos_w  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int c_dist_w = $clog2(SYNC_LEN + 1);
    localparam int c_hit_w  = $clog2(VERIFY_CNT + 1);
    localparam int c_miss_w = $clog2(LOSS_CNT + 1);

    localparam logic [c_pos_w-1:0]  c_last_pos = c_pos_w'(FRAME_LEN - 1);
    localparam logic [c_pos_w-1:0]  c_pay_end  = c_pos_w'(FRAME_LEN - SYNC_LEN);
    localparam logic [c_dist_w-1:0] c_max_mis  = c_dist_w'(MAX_MISMATCH);
    localparam logic [c_hit_w-1:0]  c_verify   = c_hit_w'(VERIFY_CNT);
    localparam logic [c_hit_w-1:0]  c_hit_one  = c_hit_w'(1);
    localparam logic [c_miss_w-1:0] c_loss     = c_miss_w'(LOSS_CNT);
    localparam logic [c_miss_w-1:0] c_miss_one = c_miss_w'(1);

    typedef enum logic [2:0] {
        ST_SEARCH   = 3'd0,
        ST_VERIFY   = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_FLYWHEEL = 3'd3
    } state_t;

    state_t              r_state;
    logic [SYNC_LEN-2:0] r_sr;
    logic [c_pos_w-1:0]  r_pos;
    logic [c_hit_w-1:0]  r_hit_cnt;
    logic [c_miss_w-1:0] r_miss_cnt;

    logic [SYNC_LEN-1:0] w_window;
    logic [SYNC_LEN-1:0] w_diff;
    logic [c_dist_w-1:0] w_dist;
    logic                w_hit;
    logic                w_chk;
    logic                w_locked;
    logic                w_payload;
    logic [c_pos_w-1:0]  w_pos_next;
    logic [c_hit_w-1:0]  w_hit_next;
    logic [c_miss_w-1:0] w_miss_next;
    logic [16:0]         w_err_sum;

    assign w_window = {r_sr, data_in};
    assign w_diff   = w_window ^ SYNC_WORD;

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            w_dist = w_dist + c_dist_w'(w_diff[i]);
        end
    end

    assign w_hit       = (w_dist <= c_max_mis);
    assign w_chk       = (r_pos == c_last_pos);
    assign w_locked    = (r_state == ST_LOCKED) || (r_state == ST_FLYWHEEL);
    assign w_payload   = w_locked && (r_pos < c_pay_end);
    assign w_pos_next  = w_chk ? '0 : r_pos + 1'b1;
    assign w_hit_next  = r_hit_cnt + 1'b1;
    assign w_miss_next = r_miss_cnt + 1'b1;
    assign w_err_sum   = {1'b0, sync_bit_errors} + 17'(w_dist);

    assign is_frame_sychronized = w_locked;
    assign synchronizer_state   = r_state;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_SEARCH;
            r_sr            <= '0;
            r_pos           <= '0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
            data_sync_out   <= 1'b0;
            data_sync_valid <= 1'b0;
            frame_start     <= 1'b0;
            lock_loss       <= 1'b0;
            sync_bit_errors <= '0;
        end else begin
            data_sync_valid <= 1'b0;
            frame_start     <= 1'b0;
            lock_loss       <= 1'b0;
            if (data_in_valid) begin
                r_sr            <= w_window[SYNC_LEN-2:0];
                data_sync_out   <= data_in;
                data_sync_valid <= w_payload;
                frame_start     <= w_payload && (r_pos == '0);
                // Error accounting only while in lock, using the pre-edge state.
                if (w_locked && w_chk) begin
                    sync_bit_errors <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
                end
                case (r_state)
                    ST_SEARCH: begin
                        if (w_dist == '0) begin
                            r_pos     <= '0;
                            r_hit_cnt <= c_hit_one;
                            r_state   <= (VERIFY_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        r_pos <= w_pos_next;
                        if (w_chk) begin
                            if (w_hit) begin
                                r_hit_cnt <= w_hit_next;
                                if (w_hit_next == c_verify) begin
                                    r_state <= ST_LOCKED;
                                end
                            end else begin
                                r_hit_cnt <= '0;
                                r_state   <= ST_SEARCH;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        r_pos <= w_pos_next;
                        if (w_chk && !w_hit) begin
                            if (c_miss_one == c_loss) begin
                                r_state    <= ST_SEARCH;
                                r_hit_cnt  <= '0;
                                r_miss_cnt <= '0;
                                lock_loss  <= 1'b1;
                            end else begin
                                r_miss_cnt <= c_miss_one;
                                r_state    <= ST_FLYWHEEL;
                            end
                        end
                    end
                    ST_FLYWHEEL: begin
                        r_pos <= w_pos_next;
                        if (w_chk) begin
                            if (w_hit) begin
                                r_miss_cnt <= '0;
                                r_state    <= ST_LOCKED;
                            end else if (w_miss_next == c_loss) begin
                                r_miss_cnt <= '0;
                                r_hit_cnt  <= '0;
                                r_state    <= ST_SEARCH;
                                lock_loss  <= 1'b1;
                            end else begin
                                r_miss_cnt <= w_miss_next;
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_SEARCH;
                        r_pos      <= '0;
                        r_hit_cnt  <= '0;
                        r_miss_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/frame_sync_param.md
Name: frame_sync_param

Overview:
- Parametrised frame synchroniser for the serial Hamming link. Sits between the encoder's serial output and the decoder's data input.
- Hunts for a configurable sync word, then confirms it over several frames before declaring lock.
- Tolerates sync-word bit errors while locked, and flywheels through missed sync words before dropping lock.
- Forwards only payload bits to the decoder, with a valid strobe and a frame-start marker. Supersedes the fixed-format synchroniser.

Parameters:
- SYNC_LEN, 8: sync word length in bits, 2..32.
- SYNC_WORD, 8'hE2: sync pattern, MSB received first.
- FRAME_LEN, 40: total bits per frame including the sync word; must be > SYNC_LEN.
- MAX_MISMATCH, 1: sync bit errors tolerated at a checkpoint; must be < SYNC_LEN/2.
- VERIFY_CNT, 2: consecutive good checkpoints needed to reach LOCKED, ≥1.
- LOSS_CNT, 3: consecutive bad checkpoints that drop lock, ≥1.

Ports:
- clk_out, input, 1: bit clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- data_in, input, 1: serial bit.
- data_in_valid, input, 1: data_in is sampled only when high.
- is_frame_sychronized, output, 1: high in LOCKED or FLYWHEEL.
- synchronizer_state, output, 3: current state encoding.
- data_sync_out, output, 1: registered payload bit.
- data_sync_valid, output, 1: data_sync_out is a payload bit.
- frame_start, output, 1: pulses with the first payload bit of each output frame.
- lock_loss, output, 1: one-cycle pulse on FLYWHEEL→SEARCH.
- sync_bit_errors, output, 16: saturating count of mismatched sync bits at checkpoints while LOCKED or FLYWHEEL.

Behaviour:
Reset
- rst_n low clears all outputs, the shift register, pos, hit_cnt and miss_cnt to 0, and sets state to SEARCH.
- Reset takes effect immediately, including mid-frame.

Hold
- When data_in_valid is low, all state is frozen and data_sync_valid and frame_start are 0.

Sync window and distance
- On each valid bit, the window is {sr[SYNC_LEN-2:0], data_in}, and sr is loaded with this window.
- dist = popcount(window XOR SYNC_WORD).

Position counter
- pos is clog2(FRAME_LEN) bits wide and counts valid bits since the last sync end, 0..FRAME_LEN-1.
- Payload occupies pos 0..FRAME_LEN-SYNC_LEN-1; the sync word occupies the remaining positions.
- A checkpoint is a valid bit with pos == FRAME_LEN-1. After it, pos wraps to 0.
- hit = dist <= MAX_MISMATCH.

States (encoding SEARCH=0, VERIFY=1, LOCKED=2, FLYWHEEL=3; values 4-7 unused and recover to SEARCH)
- SEARCH: pos is unused. On every valid bit, dist == 0 → VERIFY with pos=0 and hit_cnt=1.
- VERIFY, at a checkpoint:
  - Hit: hit_cnt+1. If the new value equals VERIFY_CNT, go to LOCKED; otherwise stay.
  - Miss: go to SEARCH with hit_cnt=0.
  - VERIFY_CNT=1 goes straight from SEARCH to LOCKED.
- LOCKED, at a checkpoint:
  - Hit: stay.
  - Miss: go to FLYWHEEL with miss_cnt=1.
- FLYWHEEL, at a checkpoint:
  - Hit: go to LOCKED with miss_cnt=0.
  - Miss: miss_cnt+1. When it reaches LOSS_CNT, go to SEARCH and pulse lock_loss.
  - LOSS_CNT=1 goes directly LOCKED→SEARCH with a lock_loss pulse.
- The checkpoint bit uses the pre-edge state; the transition applies from the next bit.

Outputs
- Latency is 1 cycle: data_sync_out is data_in registered.
- data_sync_valid = data_in_valid AND (state in LOCKED/FLYWHEEL) AND pos < FRAME_LEN-SYNC_LEN, registered.
- frame_start = data_sync_valid term AND pos == 0, registered.
- Sync bits are never forwarded.
- On drop to SEARCH, data_sync_valid is 0 from the next bit.
- sync_bit_errors adds dist at every checkpoint taken in LOCKED/FLYWHEEL and saturates at 16'hFFFF.

Test Plan:
Defaults are used throughout; a frame is E2 followed by 32 payload bits.
1. Reset: hold rst_n=0 with random data_in → all outputs 0, synchronizer_state=0. Pulse rst_n low mid-lock → outputs clear within the same cycle, no clock needed.
2. Acquisition: 7 bits 0000000, then frames F1, F2, F3 → state=1 after F1's E2, state=2 after F2's E2. Exactly 32 data_sync_valid per frame, matching F2 and F3 payload. frame_start=1 on each frame's first payload bit. No valid during F1.
3. Tolerance: LOCKED, sync=E3 (1 bit error) → stays 2, sync_bit_errors=1. Sync=E1 (2 errors) → state=3, payload still output, count=3. Next sync=E2 → state=2.
4. Loss: LOCKED, three consecutive syncs 1D → states 3,3,0. lock_loss pulses once on the third checkpoint. data_sync_valid=0 thereafter, is_frame_sychronized=0.
5. Verify fail: E2, then 32 payload bits, then 00 at the checkpoint → VERIFY then SEARCH, no valid output.
6. Stalls: in LOCKED, drop data_in_valid for 5 cycles at pos=10 → pos holds, no valid during the gap. Output payload is bit-identical and lock is retained.
